// File: rtl/lsu_pkg.sv
// Shared opcodes, access sizes, FSM states and fault codes for the RV32I load/store unit.
package lsu_pkg;
  localparam logic [6:0] LTYPE = 7'b0000011;
  localparam logic [6:0] STYPE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, CHECK, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {NONE, MISALIGN, TIMEOUT, ILLEGAL} fault_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Illegal encodings win over misalignment.
  function automatic fault_e check_fault(input logic [6:0] opcode, input logic [2:0] func3,
                                         input logic [1:0] addr_lo);
    logic is_ld, is_st;
    is_ld = (opcode == LTYPE);
    is_st = (opcode == STYPE);
    if (!is_ld && !is_st)                                          return ILLEGAL;
    if (is_ld && (func3 == 3'd3 || func3 == 3'd6 || func3 == 3'd7)) return ILLEGAL;
    if (is_st && func3 > F3_W)                                     return ILLEGAL;
    if (func3[1:0] == 2'b01 && addr_lo[0])                         return MISALIGN;
    if (func3[1:0] == 2'b10 && addr_lo != 2'b00)                   return MISALIGN;
    return NONE;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata_ext
);
  logic [31:0] lane;

  always_comb begin
    lane       = mem_rdata >> {addr_lo, 3'b000};
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    rdata_ext  = lane;
    case (func3)
      F3_B: begin
        wstrb      = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = {{24{lane[7]}}, lane[7:0]};
      end
      F3_H: begin
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = {{16{lane[15]}}, lane[15:0]};
      end
      F3_W: begin
        wstrb      = 4'b1111;
        lane_wdata = wdata;
        rdata_ext  = lane;
      end
      F3_BU:   rdata_ext = {24'b0, lane[7:0]};
      F3_HU:   rdata_ext = {16'b0, lane[15:0]};
      default: rdata_ext = lane;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory stage: validates the access, runs one req/ack transaction with a timeout, returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [7:0] LAST_WAIT = MAX_WAIT - 8'd1;

  state_e      state;
  lsu_req_t    req_q;
  logic [7:0]  wait_cnt;
  logic [3:0]  wstrb;
  logic [31:0] lane_wdata, rdata_ext;
  fault_e      chk_fault;
  logic        is_st;

  assign is_st     = (req_q.opcode == STYPE);
  assign chk_fault = check_fault(req_q.opcode, req_q.func3, req_q.addr[1:0]);

  lsu_align u_align (
    .addr_lo    (req_q.addr[1:0]),
    .func3      (req_q.func3),
    .wdata      (req_q.wdata),
    .mem_rdata  (mem_rdata),
    .wstrb      (wstrb),
    .lane_wdata (lane_wdata),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      fault       <= 1'b0;
      fault_cause <= NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req_q       <= '{opcode: opcode, func3: func3, addr: addr, wdata: wdata};
          rdata       <= '0;
          fault       <= 1'b0;
          fault_cause <= NONE;
          busy        <= 1'b1;
          state       <= CHECK;
        end
        CHECK: begin
          if (chk_fault != NONE) begin
            fault       <= 1'b1;
            fault_cause <= chk_fault;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {req_q.addr[31:2], 2'b00};
            mem_wstrb <= is_st ? wstrb : 4'b0000;
            mem_wdata <= is_st ? lane_wdata : 32'b0;
            wait_cnt  <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 8'd1;
          // An ack on the final wait cycle still completes normally.
          if (mem_ack || wait_cnt == LAST_WAIT) begin
            if (mem_ack) begin
              rdata <= is_st ? 32'b0 : rdata_ext;
            end else begin
              fault       <= 1'b1;
              fault_cause <= TIMEOUT;
            end
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy     <= 1'b0;
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
